reset_request_generator: RTL and testbench
==========================================

Name: reset_request_generator

Overview:
- Produces the chip-level active-low reset request that feeds the downstream reset synchronizers.
- Merges three sources into one clean, minimum-width reset pulse with a defined release point:
  - power-on after `asyc_rst_n` deasserts,
  - host soft-reset request (OpalKelly wire-in level),
  - board push-button.
- Reports the busy/done status and the cause of the last reset to the host.

Parameters:
- POR_CYCLES, 256, cycles `rst_out_n` is held low after `asyc_rst_n` deasserts (≥2).
- HOLD_CYCLES, 16, minimum low width of `rst_out_n` for soft/button resets (≥2).
- DEBOUNCE_CYCLES, 1024, consecutive stable samples required to change the debounced button state (≥2).
- SYNC_STAGES, 2, flop stages on each asynchronous input (≥2).

Ports:
- clk  input  1  system clock
- asyc_rst_n  input  1  asynchronous active-low reset; asserts asynchronously and is sampled on posedge clk after release
- soft_rst_req  input  1  host soft-reset level, asynchronous to clk; the rising edge triggers a reset
- btn_rst_n  input  1  push-button, active-low, asynchronous and bouncing
- rst_out_n  output  1  registered reset request, active-low
- rst_busy  output  1  high while `rst_out_n` is low
- rst_done  output  1  one-cycle pulse, in the first cycle `rst_out_n` is high after any reset
- rst_cause  output  2  last reset cause: 00 POR, 01 soft, 10 button; 11 is unused
- rst_cnt  output  8  number of soft/button resets, saturating at 255

Behaviour:
- Reset (`asyc_rst_n` = 0):
  - State = POR, all counters cleared, all synchronizer flops cleared (button synchronizer flops set to 1).
  - Outputs: `rst_out_n`=0, `rst_busy`=1, `rst_done`=0, `rst_cause`=00, `rst_cnt`=0.
  - Debounced button state = released.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops.
  - `soft_rst_req`: rising-edge detect on the synchronized level, registered. `rst_out_n` falls on the (SYNC_STAGES+1)th posedge after the input rises; this is the 3rd posedge at defaults.
  - Button debounce: counter counts consecutive synchronized samples that differ from the current debounced state.
    - When the count reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
    - Any sample equal to the current debounced state clears the counter.
  - btn_press = debounced state changing from released to pressed (one cycle).
- FSM states: POR, IDLE, ASSERT, WAIT_RELEASE.
- POR:
  - Counter increments every posedge after reset release.
  - `rst_out_n` is low for exactly POR_CYCLES posedges, then → IDLE.
  - In the IDLE-entry cycle: `rst_out_n`=1, `rst_busy`=0, `rst_done`=1.
  - Triggers arriving during POR are ignored; `rst_cnt` is unchanged.
- IDLE:
  - btn_press or soft edge → ASSERT on the next posedge: `rst_out_n`=0, `rst_busy`=1, hold counter cleared, `rst_cnt`+1 (saturating at 255).
  - `rst_cause` = 10 for button, 01 for soft. If both occur in the same cycle, button wins and the count increments by 1 only.
- ASSERT:
  - Low for HOLD_CYCLES cycles.
  - A new soft edge or btn_press reloads the hold counter: the low time is extended, `rst_cnt` is unchanged, and `rst_cause` is updated (button priority).
  - At terminal count:
    - debounced button still pressed → WAIT_RELEASE;
    - otherwise → IDLE with `rst_done` pulse.
- WAIT_RELEASE:
  - `rst_out_n` stays low until the debounced button is released, then → IDLE with `rst_done` pulse.
  - Soft edges here are ignored.
- A soft level held high does not retrigger; only a new rising edge does.
- `asyc_rst_n` assertion in any state returns the block to POR immediately; the full POR sequence repeats after release.
- All outputs are registered; no combinational path from input to output.

Test Plan (POR_CYCLES=10, HOLD_CYCLES=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
- Release `asyc_rst_n` → `rst_out_n` low for exactly 10 posedges; then `rst_out_n`=1, `rst_done`=1 for 1 cycle, `rst_cause`=00, `rst_cnt`=0.
- After POR, pulse `soft_rst_req` high for 20 cycles → `rst_out_n` falls on the 3rd posedge and stays low 4 cycles; `rst_done` pulses once; `rst_cause`=01, `rst_cnt`=1; no second reset while the level stays high.
- Button low with bounce (toggle every 3 cycles for 30 cycles), then stable low 8 cycles, held 40 cycles, then high → exactly one reset; `rst_out_n` low until 8 stable-high samples after release; `rst_cause`=10, `rst_cnt`+1.
- Soft edge 2 cycles after ASSERT entry → low time = 2 + 4 cycles, `rst_cnt` incremented only once.
- Soft edge and btn_press in the same cycle → `rst_cause`=10, `rst_cnt`+1; soft edge during POR → ignored, `rst_cnt` stays 0.
- `asyc_rst_n` pulsed low mid-ASSERT → outputs return to reset values immediately; after release a full 10-cycle POR follows and `rst_cnt`=0.
- 260 soft resets → `rst_cnt` saturates at 255.

Source files
------------

// File: rtl/reset_request_generator.sv
// Chip-level reset request generator.
// Merges power-on, host soft-reset and push-button sources into one registered,
// active-low reset request with a guaranteed minimum low width, and reports
// busy/done status, the last cause and a saturating count of soft/button resets.
module reset_request_generator #(
    parameter int unsigned POR_CYCLES      = 256,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       asyc_rst_n,
    input  logic       soft_rst_req,
    input  logic       btn_rst_n,
    output logic       rst_out_n,
    output logic       rst_busy,
    output logic       rst_done,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_cnt
);

    localparam int unsigned POR_W  = $clog2(POR_CYCLES);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;

    typedef enum logic [1:0] {
        StPor,
        StIdle,
        StAssert,
        StWaitRelease
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] soft_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   soft_prev_q;
    logic                   soft_lvl;
    logic                   soft_edge;
    logic                   btn_lvl;

    // Synchronizer chains; the button chain idles released (high).
    always_ff @(posedge clk or negedge asyc_rst_n) begin
        if (!asyc_rst_n) begin
            soft_sync_q <= '0;
            btn_sync_q  <= '1;
        end else begin
            soft_sync_q <= {soft_sync_q[SYNC_STAGES-2:0], soft_rst_req};
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_rst_n};
        end
    end

    assign soft_lvl = soft_sync_q[SYNC_STAGES-1];
    assign btn_lvl  = btn_sync_q[SYNC_STAGES-1];

    // Previous synchronized soft level; tracks even during POR so a level
    // already high when POR ends does not look like a fresh request.
    always_ff @(posedge clk or negedge asyc_rst_n) begin
        if (!asyc_rst_n) begin
            soft_prev_q <= 1'b0;
        end else begin
            soft_prev_q <= soft_lvl;
        end
    end

    assign soft_edge = soft_lvl & ~soft_prev_q;

    // ------------------------------------------------------------------
    // Button debounce
    // ------------------------------------------------------------------
    logic             db_released_q;
    logic [DEB_W-1:0] db_cnt_q;
    logic             btn_differs;
    logic             db_full;
    logic             btn_press;

    assign btn_differs = (btn_lvl != db_released_q);
    assign db_full     = (db_cnt_q == DEB_LAST);
    // Press fires in the cycle the debounced state flips released -> pressed.
    assign btn_press   = btn_differs & db_full & db_released_q;

    // Count consecutive samples disagreeing with the debounced state.
    always_ff @(posedge clk or negedge asyc_rst_n) begin
        if (!asyc_rst_n) begin
            db_released_q <= 1'b1;
            db_cnt_q      <= '0;
        end else if (!btn_differs) begin
            db_cnt_q <= '0;
        end else if (db_full) begin
            db_released_q <= ~db_released_q;
            db_cnt_q      <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + DEB_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Reset sequencing FSM
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              out_n_q, out_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        cause_q, cause_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              trigger;
    logic [1:0]        trig_cause;

    assign trigger    = btn_press | soft_edge;
    // Button wins when both sources fire in the same cycle.
    assign trig_cause = btn_press ? CAUSE_BTN : CAUSE_SOFT;

    // State and registered outputs.
    always_ff @(posedge clk or negedge asyc_rst_n) begin
        if (!asyc_rst_n) begin
            state_q    <= StPor;
            por_cnt_q  <= '0;
            hold_cnt_q <= '0;
            out_n_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            cause_q    <= CAUSE_POR;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            por_cnt_q  <= por_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            out_n_q    <= out_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        por_cnt_d  = por_cnt_q;
        hold_cnt_d = hold_cnt_q;
        out_n_d    = out_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cause_d    = cause_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StPor: begin
                // Triggers are ignored until the POR window has elapsed.
                if (por_cnt_q == POR_LAST) begin
                    state_d = StIdle;
                    out_n_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    por_cnt_d = por_cnt_q + POR_W'(1);
                end
            end

            StIdle: begin
                if (trigger) begin
                    state_d    = StAssert;
                    out_n_d    = 1'b0;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                    cause_d    = trig_cause;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            StAssert: begin
                if (trigger) begin
                    // Re-trigger stretches the pulse but is not a new reset.
                    hold_cnt_d = '0;
                    cause_d    = trig_cause;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    if (!db_released_q) begin
                        state_d = StWaitRelease;
                    end else begin
                        state_d = StIdle;
                        out_n_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            StWaitRelease: begin
                if (db_released_q) begin
                    state_d = StIdle;
                    out_n_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = StPor;
            end
        endcase
    end

    assign rst_out_n = out_n_q;
    assign rst_busy  = busy_q;
    assign rst_done  = done_q;
    assign rst_cause = cause_q;
    assign rst_cnt   = cnt_q;

endmodule

// File: tb/tb_reset_request_generator.sv
// Self-checking bench for reset_request_generator with a cycle-level reference
// model built from delay lines, run-length debounce and countdown windows.
module tb_reset_request_generator;

    localparam int unsigned POR  = 10;
    localparam int unsigned HOLD = 4;
    localparam int unsigned DEB  = 8;
    localparam int unsigned SYNC = 2;

    localparam logic [12:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 2'b00, 8'd0};

    logic       clk          = 1'b0;
    logic       asyc_rst_n   = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       btn_rst_n    = 1'b1;
    logic       rst_out_n;
    logic       rst_busy;
    logic       rst_done;
    logic [1:0] rst_cause;
    logic [7:0] rst_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_request_generator #(
        .POR_CYCLES     (POR),
        .HOLD_CYCLES    (HOLD),
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk         (clk),
        .asyc_rst_n  (asyc_rst_n),
        .soft_rst_req(soft_rst_req),
        .btn_rst_n   (btn_rst_n),
        .rst_out_n   (rst_out_n),
        .rst_busy    (rst_busy),
        .rst_done    (rst_done),
        .rst_cause   (rst_cause),
        .rst_cnt     (rst_cnt)
    );

    wire [12:0] dut_vec = {rst_out_n, rst_busy, rst_done, rst_cause, rst_cnt};

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit         soft_line[$];
    bit         btn_line[$];
    bit         m_soft_prev;
    bit         m_db_released;
    int         m_run;
    int         m_por_left;
    int         m_hold_left;
    bit         m_low;
    bit         m_wait;
    bit         m_done;
    logic [1:0] m_cause;
    int         m_cnt;

    function automatic void model_reset();
        soft_line.delete();
        btn_line.delete();
        for (int i = 0; i < SYNC; i++) begin
            soft_line.push_back(1'b0);
            btn_line.push_back(1'b1);
        end
        m_soft_prev   = 1'b0;
        m_db_released = 1'b1;
        m_run         = 0;
        m_por_left    = POR;
        m_hold_left   = 0;
        m_low         = 1'b1;
        m_wait        = 1'b0;
        m_done        = 1'b0;
        m_cause       = 2'b00;
        m_cnt         = 0;
    endfunction

    function automatic void model_step(bit soft_in, bit btn_in);
        bit s_lvl, b_lvl, s_edge, press, was_released, trig;
        soft_line.push_back(soft_in);
        btn_line.push_back(btn_in);
        s_lvl        = soft_line.pop_front();
        b_lvl        = btn_line.pop_front();
        s_edge       = s_lvl && !m_soft_prev;
        m_soft_prev  = s_lvl;
        was_released = m_db_released;
        press        = 1'b0;
        if (b_lvl != m_db_released) begin
            m_run++;
            if (m_run == DEB) begin
                m_db_released = !m_db_released;
                m_run         = 0;
                press         = was_released;
            end
        end else begin
            m_run = 0;
        end
        trig   = press || s_edge;
        m_done = 1'b0;
        if (m_por_left > 0) begin
            m_por_left--;
            if (m_por_left == 0) begin
                m_low  = 1'b0;
                m_done = 1'b1;
            end
        end else if (!m_low) begin
            if (trig) begin
                m_low       = 1'b1;
                m_wait      = 1'b0;
                m_hold_left = HOLD;
                m_cause     = press ? 2'b10 : 2'b01;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (m_wait) begin
            if (was_released) begin
                m_low  = 1'b0;
                m_wait = 1'b0;
                m_done = 1'b1;
            end
        end else if (trig) begin
            m_hold_left = HOLD;
            m_cause     = press ? 2'b10 : 2'b01;
        end else begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                if (!was_released) begin
                    m_wait = 1'b1;
                end else begin
                    m_low  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        return {~m_low, m_low, m_done, m_cause, m_cnt[7:0]};
    endfunction

    always @(posedge clk or negedge asyc_rst_n) begin
        if (!asyc_rst_n) model_reset();
        else model_step(soft_rst_req, btn_rst_n);
    end

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        int first_high = 0;
        int dones = 0;
        asyc_rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, RESET_VEC);
        end
        repeat (3) @(negedge clk);
        asyc_rst_n = 1'b1;
        for (int c = 1; c <= POR + 5; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL por_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            if (rst_out_n && first_high == 0) first_high = c;
            if (rst_done) dones++;
        end
        checks++;
        if (first_high != POR) begin
            errors++;
            $display("FAIL por_length: got %0d expected %0d", first_high, POR);
        end
        checks++;
        if (dones != 1 || rst_cause !== 2'b00 || rst_cnt !== 8'd0) begin
            errors++;
            $display("FAIL por_status: got done=%0d cause=%b cnt=%0d expected 1 00 0",
                     dones, rst_cause, rst_cnt);
        end
    endtask

    task automatic test_soft();
        int first_low = 0, lows = 0, dones = 0, falls = 0;
        logic prev_out = rst_out_n;
        soft_rst_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL soft_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            if (!rst_out_n) lows++;
            if (!rst_out_n && first_low == 0) first_low = c;
            if (prev_out && !rst_out_n) falls++;
            if (rst_done) dones++;
            prev_out = rst_out_n;
            if (c == 20) soft_rst_req = 1'b0;
        end
        checks++;
        if (first_low != SYNC + 1 || lows != HOLD) begin
            errors++;
            $display("FAIL soft_timing: got fall=%0d low=%0d expected %0d %0d",
                     first_low, lows, SYNC + 1, HOLD);
        end
        checks++;
        if (falls != 1 || dones != 1 || rst_cause !== 2'b01 || rst_cnt !== 8'd1) begin
            errors++;
            $display("FAIL soft_status: got falls=%0d done=%0d cause=%b cnt=%0d expected 1 1 01 1",
                     falls, dones, rst_cause, rst_cnt);
        end
    endtask

    task automatic test_button();
        int falls = 0, dones = 0, rel_c = 0;
        logic prev_out = rst_out_n;
        for (int i = 0; i < 98; i++) begin
            if (i < 30) begin
                if (i % 3 == 0) btn_rst_n = ~btn_rst_n;
            end else if (i < 78) begin
                btn_rst_n = 1'b0;
            end else begin
                btn_rst_n = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL button_model i=%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (prev_out && !rst_out_n) falls++;
            if (rst_done) dones++;
            if (i >= 78 && rst_out_n && rel_c == 0) rel_c = i - 77;
            prev_out = rst_out_n;
        end
        checks++;
        if (rel_c != SYNC + DEB + 1) begin
            errors++;
            $display("FAIL button_release: got %0d expected %0d", rel_c, SYNC + DEB + 1);
        end
        checks++;
        if (falls != 1 || dones != 1 || rst_cause !== 2'b10 || rst_cnt !== 8'd2) begin
            errors++;
            $display("FAIL button_status: got falls=%0d done=%0d cause=%b cnt=%0d expected 1 1 10 2",
                     falls, dones, rst_cause, rst_cnt);
        end
    endtask

    task automatic test_extend();
        int lows = 0, falls = 0;
        logic prev_out = rst_out_n;
        for (int c = 0; c < 20; c++) begin
            soft_rst_req = (c == 0 || c == 2);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL extend_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            if (!rst_out_n) lows++;
            if (prev_out && !rst_out_n) falls++;
            prev_out = rst_out_n;
        end
        checks++;
        if (lows != 2 + HOLD || falls != 1 || rst_cnt !== 8'd3) begin
            errors++;
            $display("FAIL extend_status: got low=%0d falls=%0d cnt=%0d expected %0d 1 3",
                     lows, falls, rst_cnt, 2 + HOLD);
        end
    endtask

    task automatic test_both();
        int falls = 0;
        logic prev_out = rst_out_n;
        for (int c = 0; c < 30; c++) begin
            btn_rst_n    = (c >= 14);
            soft_rst_req = (c >= 7 && c < 10);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL both_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            if (prev_out && !rst_out_n) falls++;
            prev_out = rst_out_n;
        end
        checks++;
        if (falls != 1 || rst_cause !== 2'b10 || rst_cnt !== 8'd4) begin
            errors++;
            $display("FAIL both_status: got falls=%0d cause=%b cnt=%0d expected 1 10 4",
                     falls, rst_cause, rst_cnt);
        end
    endtask

    task automatic test_random();
        int btn_left = 0;
        for (int c = 0; c < 1540; c++) begin
            if (c < 1500) begin
                if ($urandom_range(5) == 0) soft_rst_req = ~soft_rst_req;
                if (btn_left == 0) begin
                    btn_rst_n = ~btn_rst_n;
                    btn_left  = $urandom_range(24, 1);
                end else begin
                    btn_left--;
                end
            end else begin
                soft_rst_req = 1'b0;
                btn_rst_n    = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int first_high = 0, falls = 0, dones = 0;
        logic prev_out;
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rst_out_n !== 1'b0 || rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL async_pre: got out=%b cause=%b expected 0 01", rst_out_n, rst_cause);
        end
        #2;
        asyc_rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL async_immediate: got %h expected %h", dut_vec, RESET_VEC);
        end
        repeat (2) @(negedge clk);
        asyc_rst_n = 1'b1;
        prev_out   = rst_out_n;
        for (int c = 1; c <= POR + 15; c++) begin
            soft_rst_req = (c == 2 || c == 3);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL async_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            if (rst_out_n && first_high == 0) first_high = c;
            if (prev_out && !rst_out_n) falls++;
            if (rst_done) dones++;
            prev_out = rst_out_n;
        end
        checks++;
        if (first_high != POR || falls != 0 || dones != 1 || rst_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_por: got high_at=%0d falls=%0d done=%0d cnt=%0d expected %0d 0 1 0",
                     first_high, falls, dones, rst_cnt, POR);
        end
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 260; r++) begin
            soft_rst_req = 1'b1;
            @(negedge clk);
            soft_rst_req = 1'b0;
            for (int c = 0; c < 9; c++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL sat_model r=%0d: got %h expected %h", r, dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (rst_cnt !== 8'd255 || rst_out_n !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d out=%b expected 255 1", rst_cnt, rst_out_n);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_soft();
        test_button();
        test_extend();
        test_both();
        test_random();
        test_async_reset();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
